// File: rtl/led_chaser_module.sv
// rtl/led_chaser_module.sv - LED pattern stepper driven by rising edges of a timing pulse
module led_chaser_module #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Pulse_In,
  input  logic             Enable_In,
  input  logic [1:0]       Mode_In,
  output logic [WIDTH-1:0] LED_Out,
  output logic             Step_Done
);

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'd0,
    MODE_RIGHT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [WIDTH-1:0] LED_LSB  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LED_MSB  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LED_ZERO = '0;

  logic [WIDTH-1:0] led_q, led_d;
  mode_t            mode_q, mode_d;
  dir_t             dir_q, dir_d;
  logic             pulse_prev_q, pulse_prev_d;
  logic             step_done_q, step_done_d;

  logic             step;
  logic             is_onehot;
  logic [WIDTH-1:0] rot_left;
  logic [WIDTH-1:0] rot_right;
  logic [WIDTH-1:0] shift_left;
  logic [WIDTH-1:0] shift_right;

  // Initial pattern for each mode, loaded on a mode change or on recovery
  function automatic logic [WIDTH-1:0] mode_init(input mode_t m);
    case (m)
      MODE_RIGHT: mode_init = LED_MSB;
      MODE_COUNT: mode_init = LED_ZERO;
      default:    mode_init = LED_LSB;
    endcase
  endfunction

  // Next-state: edge detect, mode reload and per-mode pattern advance
  always_comb begin
    led_d        = led_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    pulse_prev_d = Pulse_In;
    step_done_d  = 1'b0;

    step        = Pulse_In & ~pulse_prev_q & Enable_In;
    is_onehot   = (led_q != LED_ZERO) && ((led_q & (led_q - LED_LSB)) == LED_ZERO);
    rot_left    = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
    rot_right   = {led_q[0], led_q[WIDTH-1:1]};
    shift_left  = {led_q[WIDTH-2:0], 1'b0};
    shift_right = {1'b0, led_q[WIDTH-1:1]};

    if (step) begin
      step_done_d = 1'b1;
      if (mode_t'(Mode_In) != mode_q) begin
        // A new mode always starts from its own initial pattern
        mode_d = mode_t'(Mode_In);
        led_d  = mode_init(mode_t'(Mode_In));
        dir_d  = DIR_LEFT;
      end else begin
        case (mode_q)
          MODE_LEFT: begin
            led_d = is_onehot ? rot_left : LED_LSB;
          end
          MODE_RIGHT: begin
            led_d = is_onehot ? rot_right : LED_MSB;
          end
          MODE_BOUNCE: begin
            if (!is_onehot) begin
              led_d = LED_LSB;
              dir_d = DIR_LEFT;
            end else if (dir_q == DIR_LEFT) begin
              led_d = shift_left;
              if (shift_left[WIDTH-1]) dir_d = DIR_RIGHT;
            end else begin
              led_d = shift_right;
              if (shift_right[0]) dir_d = DIR_LEFT;
            end
          end
          default: begin
            led_d = led_q + LED_LSB;
          end
        endcase
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      led_q        <= LED_LSB;
      mode_q       <= MODE_LEFT;
      dir_q        <= DIR_LEFT;
      pulse_prev_q <= 1'b0;
      step_done_q  <= 1'b0;
    end else begin
      led_q        <= led_d;
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      pulse_prev_q <= pulse_prev_d;
      step_done_q  <= step_done_d;
    end
  end

  assign LED_Out   = led_q;
  assign Step_Done = step_done_q;

endmodule

// File: tb/tb_led_chaser_module.sv
// tb/tb_led_chaser_module.sv - self-checking bench for led_chaser_module
module tb_led_chaser_module;

  localparam int W = 4;

  logic         CLK;
  logic         RSTn;
  logic         Pulse_In;
  logic         Enable_In;
  logic [1:0]   Mode_In;
  logic [W-1:0] LED_Out;
  logic         Step_Done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  // Reference model state: mode plus a position/phase/count abstraction
  int m_mode;
  int m_pos;
  int m_phase;
  int m_cnt;
  int m_prev;
  int m_done;

  led_chaser_module #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Pulse_In  (Pulse_In),
    .Enable_In (Enable_In),
    .Mode_In   (Mode_In),
    .LED_Out   (LED_Out),
    .Step_Done (Step_Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_led();
    int p;
    case (m_mode)
      0, 1: model_led = 1 << m_pos;
      2: begin
        p = (m_phase < W) ? m_phase : (2 * W - 2 - m_phase);
        model_led = 1 << p;
      end
      default: model_led = m_cnt;
    endcase
  endfunction

  // Model update on each clock, reset asynchronously like the board
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_mode  = 0;
      m_pos   = 0;
      m_phase = 0;
      m_cnt   = 0;
      m_prev  = 0;
      m_done  = 0;
    end else begin
      m_done = 0;
      if (Pulse_In && !m_prev && Enable_In) begin
        m_done = 1;
        if (int'(Mode_In) != m_mode) begin
          m_mode  = int'(Mode_In);
          m_pos   = (m_mode == 1) ? W - 1 : 0;
          m_phase = 0;
          m_cnt   = 0;
        end else begin
          case (m_mode)
            0: m_pos = (m_pos + 1) % W;
            1: m_pos = (m_pos + W - 1) % W;
            2: m_phase = (m_phase + 1) % (2 * W - 2);
            default: m_cnt = (m_cnt + 1) % (1 << W);
          endcase
        end
      end
      m_prev = int'(Pulse_In);
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge CLK) begin
    check("led_vs_model", int'(LED_Out), model_led());
    check("done_vs_model", int'(Step_Done), m_done);
    if (Step_Done) done_cnt++;
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic pulse();
    Pulse_In = 1'b1;
    cycles(2);
    Pulse_In = 1'b0;
    cycles(5);
  endtask

  task automatic do_reset(input logic [1:0] mode, input logic pulse_lvl);
    RSTn = 1'b0;
    Mode_In = mode;
    Pulse_In = pulse_lvl;
    cycles(3);
    RSTn = 1'b1;
  endtask

  int exp_l1 [8] = '{2, 4, 8, 1, 2, 4, 8, 1};
  int exp_b  [10] = '{1, 2, 4, 8, 4, 2, 1, 2, 4, 8};
  int d0;
  int led_hold;

  initial begin
    RSTn = 1'b0;
    Pulse_In = 1'b0;
    Enable_In = 1'b1;
    Mode_In = 2'd0;
    #12;
    check("reset_led", int'(LED_Out), 1);
    check("reset_done", int'(Step_Done), 0);
    cycles(2);
    RSTn = 1'b1;
    cycles(2);

    // Chase-left
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      pulse();
      check("chase_left", int'(LED_Out), exp_l1[i]);
    end
    check("chase_left_strobes", done_cnt - d0, 8);

    // Bounce from reset
    do_reset(2'd2, 1'b0);
    cycles(2);
    for (int i = 0; i < 10; i++) begin
      pulse();
      check("bounce", int'(LED_Out), exp_b[i]);
    end

    // Binary count with wrap
    Mode_In = 2'd3;
    for (int i = 0; i < 18; i++) begin
      pulse();
      check("count", int'(LED_Out), i % 16);
    end

    // Level held high gives one step
    d0 = done_cnt;
    Pulse_In = 1'b1;
    cycles(50);
    Pulse_In = 1'b0;
    cycles(3);
    check("held_strobes", done_cnt - d0, 1);
    check("held_led", int'(LED_Out), 2);

    // Disabled pulses are lost
    d0 = done_cnt;
    led_hold = int'(LED_Out);
    Enable_In = 1'b0;
    for (int i = 0; i < 3; i++) pulse();
    check("disabled_led", int'(LED_Out), led_hold);
    check("disabled_strobes", done_cnt - d0, 0);
    Enable_In = 1'b1;
    cycles(2);

    // Chase-right then switch to chase-left
    Mode_In = 2'd1;
    pulse();
    check("right_load", int'(LED_Out), 8);
    pulse();
    check("right_step", int'(LED_Out), 4);
    Mode_In = 2'd0;
    pulse();
    check("left_reload", int'(LED_Out), 1);
    pulse();
    check("left_after_reload", int'(LED_Out), 2);

    // Bounce into the right-going half, then asynchronous reset
    Mode_In = 2'd2;
    for (int i = 0; i < 5; i++) pulse();
    check("bounce_pre_reset", int'(LED_Out), 4);
    @(posedge CLK);
    #3;
    RSTn = 1'b0;
    #1;
    check("async_reset_led", int'(LED_Out), 1);
    check("async_reset_done", int'(Step_Done), 0);
    cycles(2);
    RSTn = 1'b1;
    cycles(2);
    pulse();
    check("bounce_reload_after_reset", int'(LED_Out), 1);
    pulse();
    check("bounce_after_reset", int'(LED_Out), 2);

    // Pulse already high when reset releases steps on the first clock
    do_reset(2'd0, 1'b1);
    cycles(1);
    check("pulse_high_at_release", int'(LED_Out), 2);
    Pulse_In = 1'b0;
    cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
